exe_hazard_ctrl: RTL
====================

Name: exe_hazard_ctrl

Overview:
Pipeline sequencing controller for the execute datapath. It keeps a shadow scoreboard of the EXE, MEM and WB slots and drives the operand-forwarding selects for the ALU/Val2 input muxes. It also generates the load-use stall, the branch flush and the memory-wait freeze for the whole pipeline. It sits beside the EXE stage, fed from ID-stage decode and MEM-stage memory handshake.

Parameters:
FWD_EN, 1, 1 = forwarding enabled; 0 = Sel_src1/2 forced 2'b00 and RAW hazards resolved by stalling.
CNT_W, 16, width of saturating performance counters.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
id_valid  in  1  ID holds a real instruction
id_src1  in  4  Rn index of ID instruction
id_src2  in  4  Rm/Rd index of ID instruction
id_src1_used  in  1  ID instruction reads src1
id_src2_used  in  1  ID instruction reads src2
id_dst  in  4  destination register of ID instruction
id_wb_en  in  1  ID instruction writes back
id_mem_r_en  in  1  ID instruction is a load
id_mem_w_en  in  1  ID instruction is a store
br_taken  in  1  branch resolved taken in EXE
mem_ready  in  1  memory completes MEM-stage access this cycle
Sel_src1  out  2  ALU input-1 mux select: 00 Val_Rn, 01 MEM_ALU_result, 10 WB_Value
Sel_src2  out  2  Val2 Rm-input mux select, same encoding
hazard_stall  out  1  hold PC and IF/ID; insert bubble into ID/EXE
flush  out  1  squash IF/ID and ID/EXE contents
freeze  out  1  hold every pipeline register
stall_cnt  out  CNT_W  cycles with hazard_stall=1, saturating
freeze_cnt  out  CNT_W  cycles with freeze=1, saturating

Behaviour:
- Shadow slots: EXE {v, dst, wb, mr, mw, s1, s2, s1u, s2u}; MEM {v, dst, wb, mr, mw}; WB {v, dst, wb}. All fields reset to 0. Counters reset to 0.
- Advance per cycle, priority freeze > flush > hazard_stall > normal:
  - freeze: all slots hold.
  - flush: EXE.v<=0; MEM<=EXE only if EXE.v; WB<=MEM.
  - hazard_stall: EXE.v<=0 (bubble); MEM<=EXE; WB<=MEM.
  - normal: EXE<=ID fields with v=id_valid; MEM<=EXE; WB<=MEM.
- Forwarding (combinational from shadow, FWD_EN=1), evaluated for src1 and src2 independently:
  - src used and EXE.v and MEM.v and MEM.wb and MEM.dst==src -> 01.
  - Else WB.v and WB.wb and WB.dst==src -> 10.
  - Else 00. MEM match wins over WB match.
  - Outputs are 00 whenever EXE.v=0.
- Load-use (FWD_EN=1): hazard_stall=1 when id_valid, EXE.v, EXE.mr, and (id_src1_used and id_src1==EXE.dst, or id_src2_used and id_src2==EXE.dst). Lasts exactly 1 cycle; the consumer then reaches EXE with the load in WB and gets Sel=10.
- FWD_EN=0: hazard_stall=1 on any used-src match with a valid write-back in EXE or MEM. Sel outputs are always 00.
- flush=br_taken & EXE.v & ~freeze. While flush=1, hazard_stall is forced to 0.
- freeze=MEM.v & (MEM.mr|MEM.mw) & ~mem_ready. While freeze=1, hazard_stall and flush are forced to 0. Sel outputs stay stable, computed from the held slots.
- Counters increment by 1 per qualifying cycle and hold at all-ones.
- Register 0 is not special: it is tracked like any other register.
- Reset mid-operation: all slots are invalid immediately (async). Outputs 00/0 until the first valid instruction.

Test Plan:
- ADD R1 in EXE, SUB reads R1 next -> cycle SUB in EXE with ADD in MEM: Sel_src1=01; one cycle later if reading R1 via a third instruction in EXE with ADD in WB: Sel=10.
- LDR R2 in EXE, ID reads R2 as src2 -> hazard_stall=1 for exactly 1 cycle, stall_cnt=1; consumer in EXE gets Sel_src2=10.
- Both MEM and WB write R3, EXE reads R3 -> Sel_src1=01.
- STR in MEM, mem_ready=0 for 3 cycles -> freeze=1 for 3 cycles, slots unchanged, freeze_cnt=3; br_taken asserted during freeze -> flush=0 until released.
- br_taken with EXE.v=1 and load-use hazard present -> flush=1, hazard_stall=0, EXE bubble next cycle.
- FWD_EN=0, ADD R4 then ORR reading R4 -> hazard_stall=1 for 2 cycles, Sel always 00; async rst low mid-stall -> hazard_stall=0 immediately, counters 0.

Source files
------------

// File: rtl/exe_hazard_ctrl.sv
// exe_hazard_ctrl: shadow EXE/MEM/WB scoreboard driving forwarding selects, load-use stall, branch flush and memory freeze
module exe_hazard_ctrl #(
   parameter bit FWD_EN = 1'b1,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [3:0]       id_src1,
   input  logic [3:0]       id_src2,
   input  logic             id_src1_used,
   input  logic             id_src2_used,
   input  logic [3:0]       id_dst,
   input  logic             id_wb_en,
   input  logic             id_mem_r_en,
   input  logic             id_mem_w_en,
   input  logic             br_taken,
   input  logic             mem_ready,
   output logic [1:0]       Sel_src1,
   output logic [1:0]       Sel_src2,
   output logic             hazard_stall,
   output logic             flush,
   output logic             freeze,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] freeze_cnt
);
   typedef struct packed {
      logic       v;
      logic [3:0] dst;
      logic       wb;
      logic       mr;
      logic       mw;
      logic [3:0] s1;
      logic [3:0] s2;
      logic       s1u;
      logic       s2u;
   } exe_t;
   typedef struct packed {
      logic       v;
      logic [3:0] dst;
      logic       wb;
      logic       mr;
      logic       mw;
   } mem_t;
   typedef struct packed {
      logic       v;
      logic [3:0] dst;
      logic       wb;
   } wb_t;
   exe_t exe_q, exe_d;
   mem_t mem_q, mem_d;
   wb_t  wb_q, wb_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, freeze_cnt_q, freeze_cnt_d;
   logic hit_exe, hit_mem, raw;
   logic [1:0] sel1_raw, sel2_raw;
   // hazard detection: the ID operands against the producers still in flight
   always_comb begin
      hit_exe = (id_src1_used && id_src1 == exe_q.dst) || (id_src2_used && id_src2 == exe_q.dst);
      hit_mem = (id_src1_used && id_src1 == mem_q.dst) || (id_src2_used && id_src2 == mem_q.dst);
      raw = FWD_EN ? (id_valid && exe_q.v && exe_q.mr && hit_exe)
                   : (id_valid && ((exe_q.v && exe_q.wb && hit_exe) || (mem_q.v && mem_q.wb && hit_mem)));
      freeze = mem_q.v && (mem_q.mr || mem_q.mw) && !mem_ready;
      flush = br_taken && exe_q.v && !freeze;
      hazard_stall = raw && !flush && !freeze;
   end
   // operand forwarding: the younger producer in MEM wins over WB
   always_comb begin
      sel1_raw = (mem_q.v && mem_q.wb && mem_q.dst == exe_q.s1) ? 2'b01 :
                 (wb_q.v && wb_q.wb && wb_q.dst == exe_q.s1) ? 2'b10 : 2'b00;
      sel2_raw = (mem_q.v && mem_q.wb && mem_q.dst == exe_q.s2) ? 2'b01 :
                 (wb_q.v && wb_q.wb && wb_q.dst == exe_q.s2) ? 2'b10 : 2'b00;
      Sel_src1 = (FWD_EN && exe_q.v && exe_q.s1u) ? sel1_raw : 2'b00;
      Sel_src2 = (FWD_EN && exe_q.v && exe_q.s2u) ? sel2_raw : 2'b00;
   end
   // slot advance: freeze holds everything, flush or stall drop a bubble into EXE
   always_comb begin
      exe_d = exe_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      if (!freeze) begin
         wb_d  = '{v: mem_q.v, dst: mem_q.dst, wb: mem_q.wb};
         mem_d = '{v: exe_q.v, dst: exe_q.dst, wb: exe_q.wb, mr: exe_q.mr, mw: exe_q.mw};
         if (flush || hazard_stall) exe_d.v = 1'b0;
         else exe_d = '{v: id_valid, dst: id_dst, wb: id_wb_en, mr: id_mem_r_en, mw: id_mem_w_en,
                        s1: id_src1, s2: id_src2, s1u: id_src1_used, s2u: id_src2_used};
      end
      stall_cnt_d  = (hazard_stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
      freeze_cnt_d = (freeze && !(&freeze_cnt_q)) ? freeze_cnt_q + CNT_W'(1) : freeze_cnt_q;
   end
   // state registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         exe_q        <= '0;
         mem_q        <= '0;
         wb_q         <= '0;
         stall_cnt_q  <= '0;
         freeze_cnt_q <= '0;
      end else begin
         exe_q        <= exe_d;
         mem_q        <= mem_d;
         wb_q         <= wb_d;
         stall_cnt_q  <= stall_cnt_d;
         freeze_cnt_q <= freeze_cnt_d;
      end
   end
   assign stall_cnt  = stall_cnt_q;
   assign freeze_cnt = freeze_cnt_q;
endmodule
